// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds FSM encodings, the bubble word and the control bundle.
package pipe_pkg;

    localparam int REG_AW_DEF = 5;
    localparam logic [31:0] NOP = 32'b0;
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ST_RSVD  = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD = '{default: 1'b0};
    localparam ctrl_t CTRL_BOOT = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exwb_en: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1
    };
    localparam ctrl_t CTRL_FLOW = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0
    };
    localparam ctrl_t CTRL_BRANCH = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1
    };
    localparam ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1
    };

    // A flushed pipeline register reads back as this bubble word.
    function automatic logic is_bubble(input logic [31:0] insn);
        return insn == NOP;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-info and control-enable bundle between datapath and controller.
// master = the controller, slave = the datapath.
interface pipeline_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) ();

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_br_taken;
    logic              dmem_req;
    logic              dmem_ack;

    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              exwb_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [1:0]        state;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_is_load, ex_rd, ex_br_taken, dmem_req, dmem_ack,
        output pc_en, ifid_en, idex_en, exwb_en,
        output ifid_flush, idex_flush, mem_err,
        output stall_cnt, flush_cnt, state
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_is_load, ex_rd, ex_br_taken, dmem_req, dmem_ack,
        input  pc_en, ifid_en, idex_en, exwb_en,
        input  ifid_flush, idex_flush, mem_err,
        input  stall_cnt, flush_cnt, state
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter for pipeline event statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] out
);

    // Count events, holding at the maximum value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else if (inc && !(&out)) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 4-stage IF-ID-EX-WB pipeline.
// Drives load enables and bubble flushes; freezes on memory misses.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipeline_ctrl_if.master   bus
);

    state_t               state_q;
    state_t               state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic                 err_q;
    logic                 err_d;
    ctrl_t                ctrl;
    logic                 stall_inc;
    logic                 flush_inc;
    logic                 resume;
    logic                 allow_miss;
    logic                 hazard;
    logic                 miss;
    logic                 tmo;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    // Load-use comparator; x0 is never a real producer.
    always_comb begin
        hazard = bus.ex_is_load && (rd != '0) &&
                 ((bus.id_use_rs1 && (rs1 == rd)) ||
                  (bus.id_use_rs2 && (rs2 == rd)));
        miss   = bus.dmem_req && !bus.dmem_ack;
        tmo    = (timer_q == TIMER_W'(MEM_TIMEOUT - 1));
    end

    // Next-state, timer, error flag and per-cycle control decision.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        err_d      = err_q;
        ctrl       = CTRL_HOLD;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        resume     = 1'b0;
        allow_miss = 1'b0;

        unique case (state_q)
            BOOT: begin
                ctrl    = CTRL_BOOT;
                state_d = RUN;
            end
            RUN: begin
                resume     = 1'b1;
                allow_miss = 1'b1;
            end
            MEM_WAIT: begin
                if (bus.dmem_ack || tmo) begin
                    resume  = 1'b1;
                    state_d = RUN;
                    if (!bus.dmem_ack) begin
                        err_d = 1'b1;
                    end
                end else begin
                    timer_d   = timer_q + 1'b1;
                    stall_inc = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // The cycle the memory access finishes behaves like RUN,
        // except a new miss cannot be taken on the same access.
        if (resume) begin
            if (allow_miss && miss) begin
                ctrl      = CTRL_HOLD;
                state_d   = MEM_WAIT;
                timer_d   = '0;
                stall_inc = 1'b1;
            end else if (bus.ex_br_taken) begin
                ctrl      = CTRL_BRANCH;
                flush_inc = 1'b1;
            end else if (hazard) begin
                ctrl      = CTRL_LOAD_USE;
                stall_inc = 1'b1;
            end else begin
                ctrl      = CTRL_FLOW;
            end
        end
    end

    // State, timeout timer and sticky memory error register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .out   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .out   (flush_cnt)
    );

    // Drive the control bundle and debug outputs.
    always_comb begin
        bus.pc_en      = ctrl.pc_en;
        bus.ifid_en    = ctrl.ifid_en;
        bus.idex_en    = ctrl.idex_en;
        bus.exwb_en    = ctrl.exwb_en;
        bus.ifid_flush = ctrl.ifid_flush;
        bus.idex_flush = ctrl.idex_flush;
        bus.mem_err    = err_q;
        bus.stall_cnt  = stall_cnt;
        bus.flush_cnt  = flush_cnt;
        bus.state      = state_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two parameterisations driven
// with the same directed and random stimulus against a cycle model.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, ld, br, req, ack;

    pipeline_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus_a ();
    pipeline_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus_b ();

    assign bus_a.id_rs1 = rs1;  assign bus_b.id_rs1 = rs1;
    assign bus_a.id_rs2 = rs2;  assign bus_b.id_rs2 = rs2;
    assign bus_a.id_use_rs1 = use1;  assign bus_b.id_use_rs1 = use1;
    assign bus_a.id_use_rs2 = use2;  assign bus_b.id_use_rs2 = use2;
    assign bus_a.ex_is_load = ld;  assign bus_b.ex_is_load = ld;
    assign bus_a.ex_rd = rd;  assign bus_b.ex_rd = rd;
    assign bus_a.ex_br_taken = br;  assign bus_b.ex_br_taken = br;
    assign bus_a.dmem_req = req;  assign bus_b.dmem_req = req;
    assign bus_a.dmem_ack = ack;  assign bus_b.dmem_ack = ack;

    pipeline_ctrl #(.REG_AW(5), .MEM_TIMEOUT(15), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.master)
    );

    pipeline_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.master)
    );

    int total = 0;
    int bad = 0;

    // Model: mode 0=boot 1=run 2=frozen on memory; waited = frozen cycles.
    int mt[2]   = '{15, 4};
    int cmax[2] = '{65535, 3};
    int m_mode[2], m_wait[2], m_sc[2], m_fc[2];
    bit m_err[2];
    int n_mode[2], n_wait[2], n_sc[2], n_fc[2];
    bit n_err[2];
    logic [5:0] e_ctl[2];
    logic [5:0] e_msk[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_wait[d] = 0;
            m_sc[d] = 0; m_fc[d] = 0; m_err[d] = 0;
        end
    endtask

    // Expected controls {pc,ifid,idex,exwb,ifid_fl,idex_fl} and next model.
    task automatic predict(input int d);
        bit lu;
        bit done;
        lu = ld && (rd != 0) &&
             ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        n_mode[d] = m_mode[d]; n_wait[d] = m_wait[d];
        n_sc[d] = m_sc[d]; n_fc[d] = m_fc[d]; n_err[d] = m_err[d];
        e_ctl[d] = 6'b000000;
        e_msk[d] = 6'b111111;
        if (!reset || m_mode[d] == 0) begin
            e_ctl[d] = 6'b000011;
            n_mode[d] = 1;
        end else begin
            done = (m_mode[d] == 1) || ack || (m_wait[d] == mt[d] - 1);
            if (!done) begin
                n_wait[d] = m_wait[d] + 1;
                n_sc[d] = sat(m_sc[d], cmax[d]);
            end else begin
                if (m_mode[d] == 2) begin
                    n_mode[d] = 1;
                    if (!ack) n_err[d] = 1;
                end
                if (m_mode[d] == 1 && req && !ack) begin
                    n_mode[d] = 2;
                    n_wait[d] = 0;
                    n_sc[d] = sat(m_sc[d], cmax[d]);
                end else if (br) begin
                    e_ctl[d] = 6'b111111;
                    n_fc[d] = sat(m_fc[d], cmax[d]);
                end else if (lu) begin
                    e_ctl[d] = 6'b000101;
                    e_msk[d] = 6'b110111;
                    n_sc[d] = sat(m_sc[d], cmax[d]);
                end else begin
                    e_ctl[d] = 6'b111100;
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [5:0] ctl,
                             input logic [1:0] st, input logic [15:0] sc,
                             input logic [15:0] fc, input logic err);
        chk($sformatf("ctl%0d", d), 32'(ctl & e_msk[d]),
            32'(e_ctl[d] & e_msk[d]));
        chk($sformatf("state%0d", d), 32'(st), 32'(m_mode[d]));
        chk($sformatf("stall_cnt%0d", d), 32'(sc), 32'(m_sc[d]));
        chk($sformatf("flush_cnt%0d", d), 32'(fc), 32'(m_fc[d]));
        chk($sformatf("mem_err%0d", d), 32'(err), 32'(m_err[d]));
    endtask

    // Inputs are already set: check this cycle, then advance the model.
    task automatic cycle();
        predict(0);
        predict(1);
        #1;
        check_dut(0, {bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en,
                      bus_a.exwb_en, bus_a.ifid_flush, bus_a.idex_flush},
                  bus_a.state, bus_a.stall_cnt, bus_a.flush_cnt,
                  bus_a.mem_err);
        check_dut(1, {bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en,
                      bus_b.exwb_en, bus_b.ifid_flush, bus_b.idex_flush},
                  bus_b.state, 16'(bus_b.stall_cnt), 16'(bus_b.flush_cnt),
                  bus_b.mem_err);
        @(posedge clk);
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                m_mode[d] = n_mode[d]; m_wait[d] = n_wait[d];
                m_sc[d] = n_sc[d]; m_fc[d] = n_fc[d]; m_err[d] = n_err[d];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0;
        ld = 0; br = 0; req = 0; ack = 0;
    endtask

    task automatic set_load_use();
        idle();
        ld = 1; rd = 5; rs2 = 5; use2 = 1; rs1 = 7; use1 = 1;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1;
        cycle();
        cycle();
        cycle();

        set_load_use();
        cycle();
        idle();
        cycle();
        set_load_use();
        rd = 0; rs2 = 0;
        cycle();
        idle();
        cycle();

        set_load_use();
        br = 1;
        cycle();
        idle();
        cycle();

        req = 1;
        repeat (3) cycle();
        ack = 1;
        cycle();
        idle();
        cycle();

        req = 1;
        repeat (6) cycle();
        idle();
        repeat (14) cycle();

        req = 1;
        repeat (3) cycle();
        reset = 0;
        model_reset();
        cycle();
        idle();
        reset = 1;
        cycle();
        cycle();

        repeat (5) begin
            set_load_use();
            cycle();
            idle();
            cycle();
        end

        for (int i = 0; i < 2000; i++) begin
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 3));
            use1 = 1'($urandom_range(0, 1));
            use2 = 1'($urandom_range(0, 1));
            ld   = 1'($urandom_range(0, 1));
            br   = ($urandom_range(0, 3) == 0);
            req  = ($urandom_range(0, 3) == 0);
            ack  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 0;
                model_reset();
            end else begin
                reset = 1;
            end
            cycle();
        end
        reset = 1;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 4-stage RISC-V pipeline (IF, ID, EX, WB). Each cycle it decides whether the PC and the IF/ID, ID/EX and EX/WB registers load, hold or are flushed to a bubble. It covers:
- load-use interlock,
- taken-branch flush,
- full-pipe freeze while a data-memory access is outstanding, with a timeout.

It sits beside the datapath and drives only enables and flushes. A flush forces the target pipeline register to 32'b0, which is a NOP bubble.

## Interface
- REG_AW, 5, register-address width
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before a forced resume (1..255)
- CNT_W, 16, width of the performance counters
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1 / rs2
- ex_is_load  in  1  the EX instruction is a load
- ex_rd  in  REG_AW  destination register of the EX instruction
- ex_br_taken  in  1  branch or jump resolved taken in EX
- dmem_req  in  1  EX issues a data-memory access this cycle
- dmem_ack  in  1  data memory completes the access
- pc_en, ifid_en, idex_en, exwb_en  out  1  register load enables
- ifid_flush, idex_flush  out  1  synchronous clear of IF/ID and ID/EX (wins over the enable)
- mem_err  out  1  sticky; set when a memory timeout fires
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters
- state  out  2  FSM state, for debug

## Operation
- FSM states: BOOT=0, RUN=1, MEM_WAIT=2. State 3 is unused and recovers to RUN.
- Asynchronous reset (reset=0) gives:
  - state=BOOT, timer=0, mem_err=0, both counters 0.
  - Outputs while reset is low and in BOOT: all enables 0, ifid_flush=1, idex_flush=1.
- BOOT lasts exactly one cycle after reset is released, then goes to RUN.
- RUN: outputs are combinational. Priority is highest first:
  1. Memory miss (dmem_req=1 and dmem_ack=0):
     - All enables 0, both flushes 0.
     - Next state MEM_WAIT, timer cleared to 0.
     - stall_cnt increments.
  2. Branch (ex_br_taken=1):
     - pc_en=1, ifid_en=1, idex_en=1, exwb_en=1.
     - ifid_flush=1, idex_flush=1, squashing 2 wrong-path instructions.
     - flush_cnt increments.
  3. Load-use hazard:
     - Condition: ex_is_load=1, ex_rd!=0, and (id_use_rs1 with id_rs1==ex_rd, or id_use_rs2 with id_rs2==ex_rd).
     - pc_en=0, ifid_en=0, idex_flush=1, exwb_en=1.
     - stall_cnt increments.
     - This is a single-cycle bubble. No extra state is needed, because the load has left EX on the next cycle.
  4. Otherwise: all enables 1, both flushes 0.
- Register x0 never creates a hazard.
- A memory access with dmem_req=1 and dmem_ack=1 in the same RUN cycle completes with no stall.
- MEM_WAIT:
  - All enables 0, both flushes 0. The EX instruction and its ex_br_taken stay frozen.
  - Each cycle: timer increments and stall_cnt increments.
  - On dmem_ack=1: go to RUN. Outputs in that same cycle follow the RUN rules, skipping rule 1.
  - If timer==MEM_TIMEOUT-1 and dmem_ack=0: set mem_err=1, go to RUN, and the access is treated as complete.
- A branch held under a freeze is acted on in the first RUN cycle after the freeze.
- Counters saturate at 2^CNT_W-1 and never wrap. mem_err clears only on reset.

## Timing
- Hazard decisions are combinational in the cycle they are detected.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 bubble cycles.
- A memory stall lasts (ack cycle − req cycle) cycles, and at most MEM_TIMEOUT.
- Counter updates and mem_err become visible 1 cycle after the event.
- Reset asserted mid-MEM_WAIT immediately gives state=BOOT, with flushes asserted asynchronously.

## Structure
- A shared package pipe_pkg holds:
  - the state encodings BOOT, RUN, MEM_WAIT;
  - the NOP constant 32'b0;
  - the REG_AW default.
- Sub-module sat_counter (width parameter, inc, out) is instantiated twice, for stall_cnt and flush_cnt.
- The hazard comparator is inline combinational logic. The FSM and timer live in pipeline_ctrl.

## Test plan
- Reset release, then no hazards → BOOT for 1 cycle with both flushes=1, then RUN with all enables=1 and state=1.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → 1 cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeating with ex_rd=0 → no stall.
- ex_br_taken=1 while the same load-use condition holds → ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- dmem_req=1, dmem_ack delayed 3 cycles → state=2 for 3 cycles, all enables 0; stall_cnt=3; RUN resumes in the ack cycle.
- dmem_req=1 and no ack with MEM_TIMEOUT=4 → 4 frozen cycles, then mem_err=1 and state=1. Pulsing reset low mid-wait → state=0 and mem_err=0 immediately.
- Counter saturation with CNT_W=2 → stall_cnt holds at 3 after 5 stalls.
